// File: rtl/hazard3_mul_wb_buffer_pkg.sv
//==============================================================================
// Module   : hazard3_mul_wb_buffer_pkg
// Desc     : Shared width constants and sizing helpers for the mul writeback path
// Revision : 1.0
//==============================================================================
`default_nettype none

package hazard3_mul_wb_buffer_pkg;

    localparam int c_W_DATA    = 32;
    localparam int c_W_REGADDR = 5;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard3_mul_wb_fifo.sv
//==============================================================================
// Module   : hazard3_mul_wb_fifo
// Desc     : DEPTH-entry {rd, data} register FIFO with per-entry valid/rd export
// Revision : 1.0
//==============================================================================
`default_nettype none

module hazard3_mul_wb_fifo
    import hazard3_mul_wb_buffer_pkg::*;
#(
    parameter  int W_DATA    = c_W_DATA,
    parameter  int W_REGADDR = c_W_REGADDR,
    parameter  int DEPTH     = 2,
    localparam int OCC_W     = occ_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_push,
    input  logic [W_REGADDR-1:0] i_push_rd,
    input  logic [W_DATA-1:0]    i_push_data,
    input  logic                 i_pop,
    input  logic                 i_flush,
    output logic                 o_head_vld,
    output logic [W_REGADDR-1:0] o_head_rd,
    output logic [W_DATA-1:0]    o_head_data,
    output logic [OCC_W-1:0]     o_occ,
    output logic [DEPTH-1:0]     o_ent_vld,
    output logic [W_REGADDR-1:0] o_ent_rd [DEPTH]
);

    localparam int               PTR_W      = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(DEPTH - 1);

    logic [W_REGADDR-1:0] r_rd_mem   [DEPTH];
    logic [W_DATA-1:0]    r_data_mem [DEPTH];
    logic [DEPTH-1:0]     r_vld;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [OCC_W-1:0]     r_occ;

    logic [PTR_W-1:0]     w_wr_ptr_nxt;
    logic [PTR_W-1:0]     w_rd_ptr_nxt;

    assign w_wr_ptr_nxt = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (i_flush) begin
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            // Clear before set: at full, push and pop hit the same slot.
            if (i_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= w_rd_ptr_nxt;
            end
            if (i_push) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= w_wr_ptr_nxt;
            end
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_rd_mem[r_wr_ptr]   <= i_push_rd;
            r_data_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Head is forced to zero when empty so stale storage never reaches the port.
    assign o_head_vld  = (r_occ != '0);
    assign o_head_rd   = o_head_vld ? r_rd_mem[r_rd_ptr]   : '0;
    assign o_head_data = o_head_vld ? r_data_mem[r_rd_ptr] : '0;
    assign o_occ       = r_occ;
    assign o_ent_vld   = r_vld;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign o_ent_rd[i] = r_rd_mem[i];
    end

endmodule

`default_nettype wire

// File: rtl/hazard3_mul_wb_buffer.sv
//==============================================================================
// Module   : hazard3_mul_wb_buffer
// Desc     : Tags fast-multiplier ops, queues results for writeback, flags hazards
// Revision : 1.0
//==============================================================================
`default_nettype none

module hazard3_mul_wb_buffer
    import hazard3_mul_wb_buffer_pkg::*;
#(
    parameter int W_DATA    = c_W_DATA,
    parameter int W_REGADDR = c_W_REGADDR,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_vld,
    input  logic [W_REGADDR-1:0] issue_rd,
    output logic                 issue_rdy,
    input  logic [W_DATA-1:0]    mul_result,
    input  logic                 mul_result_vld,
    output logic                 wb_vld,
    output logic [W_REGADDR-1:0] wb_rd,
    output logic [W_DATA-1:0]    wb_data,
    input  logic                 wb_rdy,
    input  logic                 flush,
    input  logic [W_REGADDR-1:0] hz_rs1,
    input  logic [W_REGADDR-1:0] hz_rs2,
    output logic                 hz_stall
);

    localparam int               OCC_W   = occ_width(DEPTH);
    localparam logic [OCC_W:0]   c_DEPTH = (OCC_W + 1)'(DEPTH);

    logic                 r_tag_vld;
    logic [W_REGADDR-1:0] r_tag_rd;

    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_hz;
    logic [OCC_W-1:0]     w_occ;
    logic [DEPTH-1:0]     w_ent_vld;
    logic [W_REGADDR-1:0] w_ent_rd [DEPTH];

    function automatic logic hz_hit(
        input logic [W_REGADDR-1:0] rd,
        input logic [W_REGADDR-1:0] rs1,
        input logic [W_REGADDR-1:0] rs2
    );
        return (rd != '0) && ((rd == rs1) || (rd == rs2));
    endfunction

    // Credit counts the in-flight op so a queued slot is reserved before the result lands.
    assign issue_rdy = ({1'b0, w_occ} + {{OCC_W{1'b0}}, r_tag_vld}) < c_DEPTH;
    assign w_accept  = issue_vld && issue_rdy && !flush;
    assign w_push    = r_tag_vld && !flush;
    assign w_pop     = wb_vld && wb_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= 1'b0;
            r_tag_rd  <= '0;
        end else begin
            r_tag_vld <= w_accept;
            if (w_accept) begin
                r_tag_rd <= issue_rd;
            end
        end
    end

    hazard3_mul_wb_fifo #(
        .W_DATA    (W_DATA),
        .W_REGADDR (W_REGADDR),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_rd   (r_tag_rd),
        .i_push_data (mul_result),
        .i_pop       (w_pop),
        .i_flush     (flush),
        .o_head_vld  (wb_vld),
        .o_head_rd   (wb_rd),
        .o_head_data (wb_data),
        .o_occ       (w_occ),
        .o_ent_vld   (w_ent_vld),
        .o_ent_rd    (w_ent_rd)
    );

    always_comb begin
        w_hz = r_tag_vld && hz_hit(r_tag_rd, hz_rs1, hz_rs2);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ent_vld[i] && hz_hit(w_ent_rd[i], hz_rs1, hz_rs2)) begin
                w_hz = 1'b1;
            end
        end
    end

    assign hz_stall = w_hz;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(issue_vld && !issue_rdy))
                else $error("hazard3_mul_wb_buffer: issue while not ready, op dropped");
            assert (mul_result_vld == r_tag_vld)
                else $error("hazard3_mul_wb_buffer: mul_result_vld disagrees with tag");
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard3_mul_wb_buffer.sv
//==============================================================================
// Module   : tb_hazard3_mul_wb_buffer
// Desc     : Directed + random bench against a queue-based reference model
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_hazard3_mul_wb_buffer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_vld = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_rdy;
    logic [31:0] mul_result = '0;
    logic        mul_result_vld = 1'b0;
    logic        wb_vld;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_rdy = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  hz_rs1 = '0;
    logic [4:0]  hz_rs2 = '0;
    logic        hz_stall;

    always #5 clk = ~clk;

    hazard3_mul_wb_buffer #(
        .W_DATA    (32),
        .W_REGADDR (5),
        .DEPTH     (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_vld      (issue_vld),
        .issue_rd       (issue_rd),
        .issue_rdy      (issue_rdy),
        .mul_result     (mul_result),
        .mul_result_vld (mul_result_vld),
        .wb_vld         (wb_vld),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .wb_rdy         (wb_rdy),
        .flush          (flush),
        .hz_rs1         (hz_rs1),
        .hz_rs2         (hz_rs2),
        .hz_stall       (hz_stall)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    // Reference model: results waiting for writeback, plus the one op inside the multiplier.
    ent_t        q[$];
    ent_t        inf;
    logic        inf_v = 1'b0;
    logic [31:0] cur_data = '0;

    int total = 0;
    int bad = 0;
    int wb_seen = 0;

    function automatic logic m_rdy();
        return (q.size() + (inf_v ? 1 : 0)) < DEPTH;
    endfunction

    function automatic logic m_hz(input logic [4:0] a, input logic [4:0] b);
        logic h;
        h = inf_v && (inf.rd != 0) && (inf.rd == a || inf.rd == b);
        foreach (q[i]) begin
            if ((q[i].rd != 0) && (q[i].rd == a || q[i].rd == b)) h = 1'b1;
        end
        return h;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
            else begin
                bad++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            end
    endtask

    task automatic check_model();
        chk("issue_rdy", {31'b0, issue_rdy}, {31'b0, m_rdy()});
        chk("wb_vld",    {31'b0, wb_vld},    {31'b0, q.size() != 0});
        chk("wb_rd",     {27'b0, wb_rd},     (q.size() != 0) ? {27'b0, q[0].rd} : 32'h0);
        chk("wb_data",   wb_data,            (q.size() != 0) ? q[0].data : 32'h0);
        chk("hz_stall",  {31'b0, hz_stall},  {31'b0, m_hz(hz_rs1, hz_rs2)});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wb_vld"},    {31'b0, wb_vld},    32'h0);
        chk({tag, "_wb_rd"},     {27'b0, wb_rd},     32'h0);
        chk({tag, "_wb_data"},   wb_data,            32'h0);
        chk({tag, "_issue_rdy"}, {31'b0, issue_rdy}, 32'h1);
        chk({tag, "_hz_stall"},  {31'b0, hz_stall},  32'h0);
    endtask

    // Drive one cycle's inputs at the falling edge, then check outputs against the model.
    task automatic drive(input logic iv, input logic [4:0] ird, input logic [31:0] idat,
                         input logic wr, input logic fl, input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        issue_vld      = iv && m_rdy();
        issue_rd       = ird;
        cur_data       = idat;
        wb_rdy         = wr;
        flush          = fl;
        hz_rs1         = r1;
        hz_rs2         = r2;
        mul_result_vld = inf_v;
        mul_result     = inf_v ? inf.data : $urandom();
        #1;
        check_model();
        if (wb_vld && wb_rdy) wb_seen++;
    endtask

    task automatic tick();
        logic acc;
        @(posedge clk);
        acc = issue_vld && m_rdy() && !flush;
        if (!rst_n || flush) begin
            q.delete();
            inf_v = 1'b0;
        end else begin
            if (q.size() != 0 && wb_rdy) void'(q.pop_front());
            if (inf_v) q.push_back(inf);
            inf_v = acc;
            if (acc) begin
                inf.rd   = issue_rd;
                inf.data = cur_data;
            end
        end
    endtask

    task automatic step(input logic iv, input logic [4:0] ird, input logic [31:0] idat,
                        input logic wr, input logic fl, input logic [4:0] r1, input logic [4:0] r2);
        drive(iv, ird, idat, wr, fl, r1, r2);
        tick();
    endtask

    task automatic idle(input int n, input logic wr);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'h0, wr, 1'b0, 5'd0, 5'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_iss;
        int base;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #2 rst_n = 1'b1;

        // Single op: result at N+1, writeback visible at N+2 for one cycle.
        step(1'b1, 5'd5, 32'h0000_0C00, 1'b1, 1'b0, 5'd0, 5'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 5'd0);
        chk("single_n1_vld", {31'b0, wb_vld}, 32'h0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 5'd0);
        chk("single_vld",  {31'b0, wb_vld}, 32'h1);
        chk("single_rd",   {27'b0, wb_rd},  32'd5);
        chk("single_data", wb_data,         32'h0000_0C00);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 5'd0);
        chk("single_gone", {31'b0, wb_vld}, 32'h0);
        tick();

        // Back-to-back with writeback stalled, then released.
        step(1'b1, 5'd1, $urandom(), 1'b0, 1'b0, 5'd0, 5'd0);
        step(1'b1, 5'd2, $urandom(), 1'b0, 1'b0, 5'd0, 5'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
        chk("b2b_rdy_low", {31'b0, issue_rdy}, 32'h0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
        chk("b2b_head_vld", {31'b0, wb_vld}, 32'h1);
        chk("b2b_head_rd",  {27'b0, wb_rd},  32'd1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 5'd0);
        chk("b2b_pop1_rd",  {27'b0, wb_rd},     32'd1);
        chk("b2b_pop1_rdy", {31'b0, issue_rdy}, 32'h0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 5'd0);
        chk("b2b_pop2_rd",  {27'b0, wb_rd},     32'd2);
        chk("b2b_pop2_rdy", {31'b0, issue_rdy}, 32'h1);
        tick();
        idle(2, 1'b1);

        // Continuous stream of 20 ops with writeback always ready.
        base  = wb_seen;
        n_iss = 0;
        for (int c = 0; c < 200 && (wb_seen - base) < 20; c++) begin
            drive(n_iss < 20, 5'(n_iss), $urandom(), 1'b1, 1'b0, 5'd0, 5'd0);
            if (issue_vld) n_iss++;
            tick();
        end
        chk("stream_wb_count", 32'(wb_seen - base), 32'd20);
        idle(2, 1'b1);

        // Hazard: rd=7 in the tag, rd=0 queued.
        step(1'b1, 5'd0, $urandom(), 1'b0, 1'b0, 5'd0, 5'd0);
        step(1'b1, 5'd7, $urandom(), 1'b0, 1'b0, 5'd0, 5'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd7, 5'd0);
        chk("hz_tag7", {31'b0, hz_stall}, 32'h1);
        hz_rs1 = 5'd0;
        hz_rs2 = 5'd3;
        #1;
        chk("hz_x0_ignored", {31'b0, hz_stall}, 32'h0);
        tick();
        idle(4, 1'b1);

        // Flush with one queued, one in flight, writeback ready.
        step(1'b1, 5'd3, $urandom(), 1'b0, 1'b0, 5'd0, 5'd0);
        step(1'b1, 5'd4, $urandom(), 1'b0, 1'b0, 5'd0, 5'd0);
        drive(1'b1, 5'd6, 32'h0, 1'b1, 1'b1, 5'd0, 5'd0);
        chk("flush_head_rd", {27'b0, wb_rd}, 32'd3);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd4, 5'd6);
        chk("flush_after_vld", {31'b0, wb_vld},    32'h0);
        chk("flush_after_rdy", {31'b0, issue_rdy}, 32'h1);
        chk("flush_after_hz",  {31'b0, hz_stall},  32'h0);
        tick();
        idle(3, 1'b1);

        // Asynchronous reset with two results queued.
        step(1'b1, 5'd9,  $urandom(), 1'b0, 1'b0, 5'd0, 5'd0);
        step(1'b1, 5'd10, $urandom(), 1'b0, 1'b0, 5'd0, 5'd0);
        idle(1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        q.delete();
        inf_v = 1'b0;
        idle(2, 1'b1);
        #3 rst_n = 1'b1;
        idle(3, 1'b1);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            step(($urandom() % 4) != 0, 5'($urandom_range(0, 7)), $urandom(),
                 ($urandom() % 3) != 0, ($urandom() % 25) == 0,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(6, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
